// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT input pairing stage.
//   FFT_N / FFT_IN_W : default frame length and sample width
//   fft_half()       : HALF = N/2, number of buffered samples per frame
//   fft_addr_w()     : ADDR_W = clog2(HALF), pair index / buffer address width
//   state_t          : pairing FSM states
package fft_pkg;

  localparam int FFT_N    = 32;
  localparam int FFT_IN_W = 8;

  function automatic int fft_half(input int n);
    return n / 32'sd2;
  endfunction

  function automatic int fft_addr_w(input int n);
    return $clog2(n / 32'sd2);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAIR = 2'd2
  } state_t;

endpackage

// File: rtl/fft_pairer_buf.sv
// fft_pairer_buf: first-half sample store for the pairing stage.
//   DEPTH x IN_W register file, one synchronous write port, one
//   combinational read port. Contents are intentionally not reset.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational)
module fft_pairer_buf
  import fft_pkg::*;
#(
  parameter int IN_W   = FFT_IN_W,
  parameter int DEPTH  = fft_half(FFT_N),
  parameter int ADDR_W = fft_addr_w(FFT_N)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [IN_W-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [IN_W-1:0]   rdata
);

  logic [IN_W-1:0] mem_r [DEPTH];

  // Sample write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fft_in_pairer.sv
// fft_in_pairer: reorders a natural-order real frame into butterfly pairs
// (x[k], x[k+N/2]) for the first radix-2 stage.
// Configuration macro: FFT_PAIRER_SOP_RESYNC_EN -- when defined, an
//   accepted sop outside IDLE restarts the frame and sets sticky err_sop.
// Ports:
//   clk, rst            - clock, async active-high reset
//   in_vld/in_rdy       - input handshake; in_sop marks frame start
//   in_r                - signed input sample
//   out_vld/out_rdy     - output pair handshake
//   out_r_0_16          - x[k]       (first-half operand)
//   out_r_16_32         - x[k+HALF]  (second-half operand)
//   out_idx, out_last   - pair index k, high when k = HALF-1
//   err_sop             - sticky sop protocol error
module fft_in_pairer
  import fft_pkg::*;
#(
  parameter int  IN_W   = FFT_IN_W,
  parameter int  N      = FFT_N,
  localparam int HALF   = fft_half(N),
  localparam int ADDR_W = fft_addr_w(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic                   in_sop,
  input  logic signed [IN_W-1:0] in_r,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic signed [IN_W-1:0] out_r_0_16,
  output logic signed [IN_W-1:0] out_r_16_32,
  output logic [ADDR_W-1:0]      out_idx,
  output logic                   out_last,
  output logic                   err_sop
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(HALF - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(0);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] cnt_r, cnt_s;
  logic              in_rdy_s, acc_s, abort_s;
  logic              we_s, load_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [IN_W-1:0]   rd_data_s;

  logic                   out_vld_r, out_last_r;
  logic signed [IN_W-1:0] out_a_r, out_b_r;
  logic [ADDR_W-1:0]      out_idx_r;

  fft_pairer_buf #(
    .IN_W   (IN_W),
    .DEPTH  (HALF),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (in_r),
    .raddr (cnt_r),
    .rdata (rd_data_s)
  );

  assign acc_s = in_vld && in_rdy_s;

`ifdef FFT_PAIRER_SOP_RESYNC_EN
  assign abort_s = acc_s && in_sop && (state_r != IDLE);
`else
  assign abort_s = 1'b0;
`endif

  // FSM state and frame counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= IDX_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state, counter and buffer-write decode
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    we_s    = 1'b0;
    waddr_s = cnt_r;
    load_s  = 1'b0;
    if (abort_s) begin
      // Restarted frame: this beat becomes x[0] of the new frame
      state_s = FILL;
      cnt_s   = IDX_ONE;
      we_s    = 1'b1;
      waddr_s = IDX_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (acc_s && in_sop) begin
            state_s = FILL;
            cnt_s   = IDX_ONE;
            we_s    = 1'b1;
            waddr_s = IDX_ZERO;
          end else begin
            state_s = IDLE;
          end
        end
        FILL: begin
          if (acc_s) begin
            we_s = 1'b1;
            if (cnt_r == LAST_IDX) begin
              state_s = PAIR;
              cnt_s   = IDX_ZERO;
            end else begin
              cnt_s = cnt_r + IDX_ONE;
            end
          end else begin
            state_s = FILL;
          end
        end
        PAIR: begin
          if (acc_s) begin
            load_s = 1'b1;
            if (cnt_r == LAST_IDX) begin
              state_s = IDLE;
              cnt_s   = IDX_ZERO;
            end else begin
              cnt_s = cnt_r + IDX_ONE;
            end
          end else begin
            state_s = PAIR;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = IDX_ZERO;
        end
      endcase
    end
  end

  // Input ready: in PAIR a beat is only taken when the output slot frees up
  always_comb begin
    in_rdy_s = 1'b0;
    if (rst) begin
      in_rdy_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    in_rdy_s = 1'b1;
        FILL:    in_rdy_s = 1'b1;
        PAIR:    in_rdy_s = !out_vld_r || out_rdy;
        default: in_rdy_s = 1'b0;
      endcase
    end
  end

  // Single-entry output pair register; data holds while stalled or idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_r  <= 1'b0;
      out_a_r    <= '0;
      out_b_r    <= '0;
      out_idx_r  <= IDX_ZERO;
      out_last_r <= 1'b0;
    end else if (load_s) begin
      out_vld_r  <= 1'b1;
      out_a_r    <= rd_data_s;
      out_b_r    <= in_r;
      out_idx_r  <= cnt_r;
      out_last_r <= (cnt_r == LAST_IDX);
    end else if (out_rdy) begin
      out_vld_r <= 1'b0;
    end
  end

`ifdef FFT_PAIRER_SOP_RESYNC_EN
  logic err_r;

  // Sticky flag for a sop seen mid-frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (abort_s) begin
      err_r <= 1'b1;
    end
  end

  assign err_sop = err_r;
`else
  assign err_sop = 1'b0;
`endif

  assign in_rdy      = in_rdy_s;
  assign out_vld     = out_vld_r;
  assign out_r_0_16  = out_a_r;
  assign out_r_16_32 = out_b_r;
  assign out_idx     = out_idx_r;
  assign out_last    = out_last_r;

endmodule

// File: tb/tb_fft_in_pairer.sv
// tb_fft_in_pairer: self-checking bench for fft_in_pairer (N=32, IN_W=8).
// A reference pairing model fed on every accepted beat pushes expected
// pairs into a scoreboard queue; a negedge monitor pops on each transfer.
module tb_fft_in_pairer;

`ifdef FFT_PAIRER_SOP_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              in_vld;
  logic              in_rdy;
  logic              in_sop;
  logic signed [7:0] in_r;
  logic              out_vld;
  logic              out_rdy;
  logic signed [7:0] out_r_0_16;
  logic signed [7:0] out_r_16_32;
  logic [3:0]        out_idx;
  logic              out_last;
  logic              err_sop;

  fft_in_pairer #(.IN_W(8), .N(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .in_sop      (in_sop),
    .in_r        (in_r),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_r_0_16  (out_r_0_16),
    .out_r_16_32 (out_r_16_32),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .err_sop     (err_sop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic [3:0]        idx;
    logic              last;
  } pair_t;

  typedef struct {
    logic signed [7:0] lo;
    logic signed [7:0] hi;
    logic signed [7:0] exp_a;
    logic signed [7:0] exp_b;
  } vec_t;

  pair_t sbq[$];
  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int pairs_seen = 0;
  logic signed [7:0] last_a, last_b;

  // reference model state
  int mstate = 0;
  int mcnt = 0;
  logic merr = 1'b0;
  logic signed [7:0] mbuf [16];

  function automatic void model_reset();
    mstate = 0;
    mcnt   = 0;
    merr   = 1'b0;
  endfunction

  function automatic void model_accept(input logic signed [7:0] d, input logic s);
    pair_t p;
    if (mstate != 0 && RESYNC && s) begin
      mbuf[0] = d;
      mcnt    = 1;
      mstate  = 1;
      merr    = 1'b1;
    end else if (mstate == 0) begin
      if (s) begin
        mbuf[0] = d;
        mcnt    = 1;
        mstate  = 1;
      end
    end else if (mstate == 1) begin
      mbuf[mcnt] = d;
      if (mcnt == 15) begin
        mcnt = 0;
        mstate = 2;
      end else begin
        mcnt++;
      end
    end else begin
      p.a = mbuf[mcnt];
      p.b = d;
      p.idx = 4'(mcnt);
      p.last = (mcnt == 15);
      sbq.push_back(p);
      if (mcnt == 15) begin
        mcnt = 0;
        mstate = 0;
      end else begin
        mcnt++;
      end
    end
  endfunction

  task automatic chk(input string name, input logic ok, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // drive one beat starting just after a posedge; returns just after the accepting edge
  task automatic send(input logic signed [7:0] d, input logic s);
    int guard = 0;
    in_vld = 1'b1;
    in_r   = d;
    in_sop = s;
    @(negedge clk);
    while (!in_rdy && guard < 200) begin
      guard++;
      stall_cnt++;
      @(negedge clk);
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_rdy stuck low, got %0d expected 1", in_rdy);
    end else begin
      model_accept(d, s);
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    in_sop = 1'b0;
  endtask

  task automatic send_ramp(input int base);
    for (int i = 0; i < 32; i++) send(8'(base + i), i == 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // stall the output for 3 cycles once pair k of a 0..31 ramp is presented
  task automatic stall_at(input int k);
    int guard = 0;
    @(posedge clk);
    #1;
    while (!(out_vld && out_idx == 4'(k)) && guard < 200) begin
      guard++;
      @(posedge clk);
      #1;
    end
    chk("stall_wait", out_vld && out_idx == 4'(k), int'(out_idx), k);
    if (out_vld && out_idx == 4'(k)) begin
      out_rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("stall_hold_a", out_r_0_16 == 8'(k) && out_vld, int'(out_r_0_16), k);
        chk("stall_hold_b", out_r_16_32 == 8'(k + 16) && out_idx == 4'(k), int'(out_r_16_32), k + 16);
        chk("stall_in_rdy", in_rdy == 1'b0, int'(in_rdy), 0);
      end
      @(posedge clk);
      #1;
      out_rdy = 1'b1;
    end
  endtask

  // output monitor: compare every transferred pair with the scoreboard
  always @(negedge clk) begin
    pair_t e;
    if (!rst && out_vld && out_rdy) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL pair_unexpected: got (%0d,%0d) idx %0d, expected none",
                 out_r_0_16, out_r_16_32, out_idx);
      end else begin
        e = sbq.pop_front();
        if (out_r_0_16 !== e.a || out_r_16_32 !== e.b || out_idx !== e.idx || out_last !== e.last) begin
          errors++;
          $display("FAIL pair: got (%0d,%0d) idx %0d last %0d, expected (%0d,%0d) idx %0d last %0d",
                   out_r_0_16, out_r_16_32, out_idx, out_last, e.a, e.b, e.idx, e.last);
        end
      end
      pairs_seen++;
      last_a = out_r_0_16;
      last_b = out_r_16_32;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

  initial begin
    vec_t vtab[4];
    int p0;
    vtab[0] = '{8'h80, 8'h7F, 8'h80, 8'h7F};
    vtab[1] = '{8'h7F, 8'h80, 8'h7F, 8'h80};
    vtab[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vtab[3] = '{8'h55, 8'hAA, 8'h55, 8'hAA};

    rst = 1'b1;
    in_vld = 1'b0;
    in_sop = 1'b0;
    in_r = 8'sd0;
    out_rdy = 1'b1;
    #3;
    chk("reset_out_vld", out_vld == 1'b0, int'(out_vld), 0);
    chk("reset_in_rdy", in_rdy == 1'b0, int'(in_rdy), 0);
    chk("reset_outputs", out_r_0_16 == 8'sd0 && out_r_16_32 == 8'sd0 && out_idx == 4'd0
        && out_last == 1'b0 && err_sop == 1'b0, int'(out_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_rdy", in_rdy == 1'b1, int'(in_rdy), 1);

    // basic frame with latency check
    for (int i = 0; i < 32; i++) begin
      send(8'(i), i == 0);
      if (i == 15) chk("no_out_in_fill", out_vld == 1'b0, int'(out_vld), 0);
      if (i == 16) chk("first_pair_latency", out_vld == 1'b1 && out_r_0_16 == 8'sd0
                       && out_r_16_32 == 8'sd16 && out_idx == 4'd0, int'(out_r_16_32), 16);
      if (i == 31) chk("last_flag", out_last == 1'b1 && out_idx == 4'd15, int'(out_last), 1);
    end
    idle_cycles(3);
    chk("out_vld_clears", out_vld == 1'b0, int'(out_vld), 0);

    // signed passthrough table
    for (int v = 0; v < 4; v++) begin
      p0 = pairs_seen;
      for (int i = 0; i < 32; i++) send(i < 16 ? vtab[v].lo : vtab[v].hi, i == 0);
      idle_cycles(3);
      chk("vec_pair_count", pairs_seen - p0 == 16, pairs_seen - p0, 16);
      chk("vec_operand_a", last_a == vtab[v].exp_a, int'(last_a), int'(vtab[v].exp_a));
      chk("vec_operand_b", last_b == vtab[v].exp_b, int'(last_b), int'(vtab[v].exp_b));
    end

    // backpressure at k = 5
    p0 = pairs_seen;
    fork
      send_ramp(0);
      stall_at(5);
    join
    idle_cycles(3);
    chk("stall_pair_count", pairs_seen - p0 == 16, pairs_seen - p0, 16);

    // pre-sop beats dropped, then two back-to-back frames
    for (int i = 0; i < 4; i++) send(8'(90 + i), 1'b0);
    stall_cnt = 0;
    p0 = pairs_seen;
    send_ramp(-20);
    send_ramp(50);
    idle_cycles(3);
    chk("b2b_no_gap", stall_cnt == 0, stall_cnt, 0);
    chk("b2b_pair_count", pairs_seen - p0 == 32, pairs_seen - p0, 32);

    // async reset mid-PAIR at k = 7
    for (int i = 0; i < 24; i++) send(8'(i), i == 0);
    chk("pre_reset_idx", out_vld == 1'b1 && out_idx == 4'd7, int'(out_idx), 7);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_vld", out_vld == 1'b0 && out_idx == 4'd0, int'(out_vld), 0);
    chk("async_reset_rdy", in_rdy == 1'b0, int'(in_rdy), 0);
    sbq.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    p0 = pairs_seen;
    for (int i = 0; i < 32; i++) send(8'(3 * i - 40), i == 0);
    idle_cycles(3);
    chk("post_reset_pairs", pairs_seen - p0 == 16, pairs_seen - p0, 16);

    // sop at FILL beat 9
    for (int i = 0; i < 9; i++) send(8'(i + 1), i == 0);
    send(8'sd40, 1'b1);
    for (int i = 0; i < 31; i++) send(8'(41 + i), 1'b0);
    idle_cycles(3);
    chk("err_sop", err_sop == merr, int'(err_sop), int'(merr));
    chk("err_sop_mode", merr == RESYNC, int'(merr), int'(RESYNC));
    send_ramp(7);
    idle_cycles(3);

    chk("scoreboard_empty", sbq.size() == 0, sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_in_pairer.md
Name: fft_in_pairer

Overview:
- Input-reordering stage directly upstream of the first real radix-2 butterfly.
- Accepts one signed real sample per beat in natural order, N samples per frame.
- Buffers the first half of each frame.
- Emits the pairs (x[k], x[k+N/2]) for k = 0..N/2-1 on the butterfly's two operand inputs, with a valid/ready handshake.

Parameters:
- IN_W, 8, sample width in bits; two's complement.
- N, 32, frame length; power of two, N >= 4.
- Derived localparam HALF = N/2.
- Derived localparam ADDR_W = clog2(HALF).

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_vld  in  1  input sample valid
- in_rdy  out  1  input ready; a beat is accepted when in_vld && in_rdy
- in_sop  in  1  start-of-frame, qualified by in_vld
- in_r  in  IN_W  signed input sample
- out_vld  out  1  output pair valid
- out_rdy  in  1  downstream ready; a pair is taken when out_vld && out_rdy
- out_r_0_16  out  IN_W  signed x[k], first-half operand
- out_r_16_32  out  IN_W  signed x[k+HALF], second-half operand
- out_idx  out  ADDR_W  pair index k
- out_last  out  1  high on the pair with k = HALF-1
- err_sop  out  1  sticky protocol error flag (see Optional Feature)

Behaviour:
- Reset (async assert, release sync to clk):
  - state = IDLE, cnt = 0.
  - out_vld, out_r_0_16, out_r_16_32, out_idx, out_last, err_sop all 0.
  - in_rdy = 0 while rst is high.
  - Buffer contents are not reset.
- Storage: HALF x IN_W register file; synchronous write, combinational read at cnt.
- State IDLE:
  - in_rdy = 1.
  - Accepted beat with in_sop = 1: write buf[0], cnt = 1, go to FILL.
  - Accepted beats with in_sop = 0 are dropped.
- State FILL:
  - in_rdy = 1.
  - Each accepted beat writes buf[cnt] and increments cnt.
  - The beat written at cnt = HALF-1 sets cnt = 0 and moves to PAIR.
  - No output is produced during FILL.
- State PAIR:
  - in_rdy = !out_vld || out_rdy (single-entry output register, no bubble on continuous ready).
  - On an accepted beat, the output registers load on the same edge:
    - out_r_0_16 <= buf[cnt]
    - out_r_16_32 <= in_r
    - out_idx <= cnt
    - out_last <= (cnt == HALF-1)
    - out_vld <= 1
    - cnt increments.
  - The beat at cnt = HALF-1 sets cnt = 0 and returns to IDLE.
- Latency: 1 cycle from accepting the second-half sample to out_vld.
- Output hold: while out_vld && !out_rdy, all out_* stay stable and in_rdy = 0.
- out_vld clears after a transfer cycle with no new accept.
- Frames may run back to back: an IDLE sop beat can be accepted the cycle after the last PAIR beat.
- Widths: samples pass bit-exact and sign-preserving; the block does no arithmetic. Bit growth is handled by the butterfly.
- Throughput: in steady state, HALF output pairs per N input beats.
- Reset mid-frame: the partial frame is discarded and the block waits for a new sop.

Optional Feature:
- Macro: FFT_PAIRER_SOP_RESYNC_EN.
- Defined: an accepted in_sop in FILL or PAIR aborts the current frame.
  - That beat is written to buf[0], cnt = 1, state = FILL.
  - A pending output pair is still delivered.
  - err_sop is set to 1 and stays set until rst.
- Undefined: in_sop outside IDLE is ignored; the beat is treated as ordinary data. err_sop is tied to 0.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_N and IN_W defaults
  - HALF and ADDR_W derivation
  - state enum {IDLE, FILL, PAIR}
- One sub-module, fft_pairer_buf: HALF-entry register file, one write port, one asynchronous read port, no reset.
- The FSM, counter and output register stay in fft_in_pairer.

Test Plan:
- Basic frame:
  - Stimulus: N = 32, out_rdy = 1, in_sop on the first beat, in_r = 0..31 consecutive.
  - Response: 16 pairs (0,16), (1,17) .. (15,31); out_idx 0..15; out_last only on (15,31); first out_vld one cycle after sample 16 is accepted.
- Signed passthrough:
  - Stimulus: first half all -128, second half all 127.
  - Response: every pair is out_r_0_16 = -128, out_r_16_32 = 127, bit-exact.
- Backpressure:
  - Stimulus: hold out_rdy = 0 for 3 cycles at pair k = 5.
  - Response: out_* stable (5,21); in_rdy = 0 throughout the stall; no sample lost or duplicated.
- Pre-sop and back-to-back:
  - Stimulus: 4 beats with in_sop = 0, then two consecutive frames.
  - Response: the 4 beats are dropped; both frames pair correctly with no gap at the boundary.
- Async reset:
  - Stimulus: assert rst mid-PAIR at k = 7.
  - Response: out_vld = 0 and state IDLE immediately; the next sop frame produces correct pairs.
- Resync (with FFT_PAIRER_SOP_RESYNC_EN):
  - Stimulus: sop at FILL beat 9.
  - Response: err_sop = 1; the frame restarts from that beat.
  - Without the macro: err_sop stays 0 and the original framing is kept.
